// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute slice: opcode/funct codes,
// FSM state encoding and instruction field-slice helpers.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;

  // Link register written by jal
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic [5:0] f_op(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] instr);
    return instr[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [31:0] f_sext_imm(input logic [31:0] instr);
    return {{16{instr[15]}}, instr[15:0]};
  endfunction

  // Pseudo-direct jump target with no PC upper bits available here
  function automatic logic [31:0] f_jump_target(input logic [31:0] instr);
    return {4'b0000, instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all)
//   i_raddr_a/o_rdata_a : operand read port A (combinational)
//   i_raddr_b/o_rdata_b : operand read port B (combinational)
//   i_raddr_d/o_rdata_d : narrow debug read port for the LED view
//   i_we/i_waddr/i_wdata: synchronous write port; writes to $0 are dropped
module mips_regfile #(
  parameter int DBG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_raddr_a,
  output logic [31:0]      o_rdata_a,
  input  logic [4:0]       i_raddr_b,
  output logic [31:0]      o_rdata_b,
  input  logic [4:0]       i_raddr_d,
  output logic [DBG_W-1:0] o_rdata_d,
  input  logic             i_we,
  input  logic [4:0]       i_waddr,
  input  logic [31:0]      i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];
  assign o_rdata_d = (i_raddr_d == 5'd0) ? '0 : r_regs[i_raddr_d][DBG_W-1:0];

endmodule

// File: rtl/mips_exec_stage.sv
// MIPS execute stage: accepts one instruction per valid/ready handshake and
// runs it through READ -> EXEC -> WB, writing the register file / data memory.
//   clk, rst_n               : clock, asynchronous active-low reset
//   instr_valid/instr_data   : upstream instruction, taken when instr_ready
//   instr_ready              : high only while idle
//   wb_valid/wb_reg/wb_data  : one-cycle pulse per register write
//   jump_valid/jump_target   : one-cycle pulse per j/jal
//   switch, dbg_sel, led     : LED view (register low bits or retired count)
module mips_exec_stage
  import mips_pkg::*;
#(
  parameter int DMEM_DEPTH = 16,
  parameter int LED_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr_data,
  output logic             instr_ready,
  output logic             wb_valid,
  output logic [4:0]       wb_reg,
  output logic [31:0]      wb_data,
  output logic             jump_valid,
  output logic [31:0]      jump_target,
  input  logic             switch,
  input  logic [4:0]       dbg_sel,
  output logic [LED_W-1:0] led
);

  localparam int AW = $clog2(DMEM_DEPTH);

  state_t            r_state;
  logic [31:0]       r_cur;
  logic [31:0]       r_opa;
  logic [31:0]       r_opb;
  logic [31:0]       r_result;
  logic [AW-1:0]     r_ea_idx;
  logic              r_legal;
  logic              r_wr_en;
  logic [4:0]        r_wr_reg;
  logic              r_is_lw;
  logic              r_is_sw;
  logic              r_is_jump;
  logic              r_instr_ready;
  logic              r_wb_valid;
  logic [4:0]        r_wb_reg;
  logic [31:0]       r_wb_data;
  logic              r_jump_valid;
  logic [31:0]       r_jump_target;
  logic [7:0]        r_retired_cnt;
  logic [7:0]        r_illegal_cnt;
  logic [LED_W-1:0]  r_led;
  logic [31:0]       r_dmem [DMEM_DEPTH];

  logic [31:0]       w_rdata_a;
  logic [31:0]       w_rdata_b;
  logic [LED_W-1:0]  w_dbg_data;
  logic              w_rf_we;
  logic [31:0]       w_imm_sext;
  logic [AW-1:0]     w_ea_idx;
  logic [31:0]       w_wb_value;

  logic              w_legal;
  logic              w_wr_en;
  logic [4:0]        w_wr_reg;
  logic [31:0]       w_result;
  logic              w_is_lw;
  logic              w_is_sw;
  logic              w_is_jump;

  // Register file write lands on the same edge that raises wb_valid, so the
  // next instruction's READ (at least two edges later) sees the new value.
  assign w_rf_we = (r_state == ST_WB) && r_wr_en;

  mips_regfile #(
    .DBG_W (LED_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (f_rs(r_cur)),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (f_rt(r_cur)),
    .o_rdata_b (w_rdata_b),
    .i_raddr_d (dbg_sel),
    .o_rdata_d (w_dbg_data),
    .i_we      (w_rf_we),
    .i_waddr   (r_wr_reg),
    .i_wdata   (w_wb_value)
  );

  assign w_imm_sext = f_sext_imm(r_cur);
  // Only the word index of the effective address matters; the bits above it
  // and the byte offset are dropped.
  assign w_ea_idx   = AW'((r_opa + w_imm_sext) >> 2);
  assign w_wb_value = r_is_lw ? r_dmem[r_ea_idx] : r_result;

  // Decode and execute from the captured operands
  always_comb begin
    w_legal   = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_reg  = 5'd0;
    w_result  = 32'd0;
    w_is_lw   = 1'b0;
    w_is_sw   = 1'b0;
    w_is_jump = 1'b0;
    case (f_op(r_cur))
      OP_RTYPE: begin
        w_wr_reg = f_rd(r_cur);
        case (f_funct(r_cur))
          FN_ADD, FN_ADDU: begin
            w_legal  = 1'b1;
            w_wr_en  = 1'b1;
            w_result = r_opa + r_opb;
          end
          FN_SLL: begin
            w_legal  = 1'b1;
            w_wr_en  = 1'b1;
            w_result = r_opb << f_shamt(r_cur);
          end
          FN_SRL: begin
            w_legal  = 1'b1;
            w_wr_en  = 1'b1;
            w_result = r_opb >> f_shamt(r_cur);
          end
          FN_SLLV: begin
            w_legal  = 1'b1;
            w_wr_en  = 1'b1;
            w_result = r_opb << r_opa[4:0];
          end
          FN_SRLV: begin
            w_legal  = 1'b1;
            w_wr_en  = 1'b1;
            w_result = r_opb >> r_opa[4:0];
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_legal  = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_reg = f_rt(r_cur);
        w_result = r_opa + w_imm_sext;
      end
      OP_LW: begin
        w_legal  = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_reg = f_rt(r_cur);
        w_is_lw  = 1'b1;
      end
      OP_SW: begin
        w_legal = 1'b1;
        w_is_sw = 1'b1;
      end
      OP_J: begin
        w_legal   = 1'b1;
        w_is_jump = 1'b1;
      end
      OP_JAL: begin
        // No PC is visible in this stage, so the link value is zero
        w_legal   = 1'b1;
        w_is_jump = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_reg  = REG_RA;
        w_result  = 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cur         <= '0;
      r_opa         <= '0;
      r_opb         <= '0;
      r_result      <= '0;
      r_ea_idx      <= '0;
      r_legal       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_reg      <= '0;
      r_is_lw       <= 1'b0;
      r_is_sw       <= 1'b0;
      r_is_jump     <= 1'b0;
      r_instr_ready <= 1'b1;
      r_wb_valid    <= 1'b0;
      r_wb_reg      <= '0;
      r_wb_data     <= '0;
      r_jump_valid  <= 1'b0;
      r_jump_target <= '0;
      r_retired_cnt <= '0;
      r_illegal_cnt <= '0;
      r_led         <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_dmem[i] <= '0;
      end
    end else begin
      r_wb_valid   <= 1'b0;
      r_jump_valid <= 1'b0;
      r_led        <= switch ? LED_W'(r_retired_cnt) : w_dbg_data;
      case (r_state)
        // Stage boundary: capture the accepted word
        ST_IDLE: begin
          if (instr_valid) begin
            r_cur         <= instr_data;
            r_instr_ready <= 1'b0;
            r_state       <= ST_READ;
          end
        end
        // Stage boundary: operand read
        ST_READ: begin
          r_opa   <= w_rdata_a;
          r_opb   <= w_rdata_b;
          r_state <= ST_EXEC;
        end
        // Stage boundary: execute result / effective address
        ST_EXEC: begin
          r_result  <= w_result;
          r_ea_idx  <= w_ea_idx;
          r_legal   <= w_legal;
          r_wr_en   <= w_wr_en;
          r_wr_reg  <= w_wr_reg;
          r_is_lw   <= w_is_lw;
          r_is_sw   <= w_is_sw;
          r_is_jump <= w_is_jump;
          r_state   <= ST_WB;
        end
        // Stage boundary: write back, pulses and counters
        ST_WB: begin
          if (r_legal) begin
            r_retired_cnt <= r_retired_cnt + 8'd1;
            if (r_wr_en) begin
              r_wb_valid <= 1'b1;
              r_wb_reg   <= r_wr_reg;
              r_wb_data  <= w_wb_value;
            end
            if (r_is_sw) begin
              r_dmem[r_ea_idx] <= r_opb;
            end
            if (r_is_jump) begin
              r_jump_valid  <= 1'b1;
              r_jump_target <= f_jump_target(r_cur);
            end
          end else if (r_illegal_cnt != 8'hFF) begin
            r_illegal_cnt <= r_illegal_cnt + 8'd1;
          end
          r_instr_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_instr_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign wb_valid    = r_wb_valid;
  assign wb_reg      = r_wb_reg;
  assign wb_data     = r_wb_data;
  assign jump_valid  = r_jump_valid;
  assign jump_target = r_jump_target;
  assign led         = r_led;

endmodule

// File: tb/tb_mips_exec_stage.sv
module tb_mips_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_data = 32'd0;
  logic        instr_ready;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        switch = 1'b0;
  logic [4:0]  dbg_sel = 5'd0;
  logic [7:0]  led;

  int n_pass = 0;
  int n_total = 0;

  mips_exec_stage #(.DMEM_DEPTH(16), .LED_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .switch      (switch),
    .dbg_sel     (dbg_sel),
    .led         (led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // Presents one word, waits (bounded) for acceptance, then watches six
  // cycles for pulses. lat counts edges after the accepting edge.
  task automatic issue(input logic [31:0] w, output bit acc, output int wb_cnt,
                       output logic [4:0] rg, output logic [31:0] dat, output int jmp_cnt,
                       output logic [31:0] tgt, output int lat);
    acc = 1'b0; wb_cnt = 0; jmp_cnt = 0; rg = 5'd0; dat = 32'd0; tgt = 32'd0; lat = -1;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = w;
    for (int i = 0; i < 10; i++) begin
      if (instr_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_data  = 32'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (wb_valid) begin
        wb_cnt++; rg = wb_reg; dat = wb_data; lat = k;
      end
      if (jump_valid) begin
        jmp_cnt++; tgt = jump_target; lat = k;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", instr_ready); else n_pass++;
    n_total++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else n_pass++;
    n_total++; if (wb_reg !== 5'd0) $display("FAIL reset_wb_reg got %h want 0", wb_reg); else n_pass++;
    n_total++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data got %h want 0", wb_data); else n_pass++;
    n_total++; if (jump_valid !== 1'b0) $display("FAIL reset_jump_valid got %b want 0", jump_valid); else n_pass++;
    n_total++; if (jump_target !== 32'd0) $display("FAIL reset_jump_target got %h want 0", jump_target); else n_pass++;
    n_total++; if (led !== 8'd0) $display("FAIL reset_led got %h want 0", led); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs a table of register-writing instructions and checks each pulse
  task automatic run_wb_table(input string name, input logic [31:0] w[3],
                              input logic [4:0] er[3], input logic [31:0] ed[3]);
    bit acc; int wbc, jc, lat; logic [4:0] rg; logic [31:0] dat, tgt;
    for (int i = 0; i < 3; i++) begin
      issue(w[i], acc, wbc, rg, dat, jc, tgt, lat);
      n_total++; if (acc !== 1'b1) $display("FAIL %s[%0d]_accept timed out", name, i); else n_pass++;
      n_total++; if (wbc != 1) $display("FAIL %s[%0d]_wb_count got %0d want 1", name, i, wbc); else n_pass++;
      n_total++; if (rg !== er[i]) $display("FAIL %s[%0d]_wb_reg got %0d want %0d", name, i, rg, er[i]); else n_pass++;
      n_total++; if (dat !== ed[i]) $display("FAIL %s[%0d]_wb_data got %h want %h", name, i, dat, ed[i]); else n_pass++;
      n_total++; if (lat != 3) $display("FAIL %s[%0d]_latency got %0d want 3", name, i, lat); else n_pass++;
    end
  endtask

  task automatic test_arith();
    logic [31:0] w[3];
    logic [4:0]  er[3];
    logic [31:0] ed[3];
    w[0] = enc_i(6'h08, 5'd0, 5'd4, 16'h3456);         er[0] = 5'd4; ed[0] = 32'h0000_3456;
    w[1] = enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF);         er[1] = 5'd5; ed[1] = 32'hFFFF_FFFF;
    w[2] = enc_r(5'd5, 5'd4, 5'd6, 5'd0, 6'h20);       er[2] = 5'd6; ed[2] = 32'h0000_3455;
    run_wb_table("arith", w, er, ed);
  endtask

  task automatic test_shift();
    logic [31:0] w[3];
    logic [4:0]  er[3];
    logic [31:0] ed[3];
    w[0] = enc_i(6'h08, 5'd0, 5'd3, 16'h0007);         er[0] = 5'd3; ed[0] = 32'h0000_0007;
    w[1] = enc_r(5'd3, 5'd6, 5'd6, 5'd0, 6'h04);       er[1] = 5'd6; ed[1] = 32'h001A_2A80;
    w[2] = enc_r(5'd0, 5'd3, 5'd3, 5'd1, 6'h02);       er[2] = 5'd3; ed[2] = 32'h0000_0003;
    run_wb_table("shift", w, er, ed);
    @(negedge clk);
    switch = 1'b1;
    @(posedge clk); #1;
    n_total++; if (led !== 8'h06) $display("FAIL led_retired got %h want 06", led); else n_pass++;
  endtask

  task automatic test_mem();
    bit acc; int wbc, jc, lat; logic [4:0] rg; logic [31:0] dat, tgt;
    issue(enc_i(6'h2B, 5'd0, 5'd4, 16'h0004), acc, wbc, rg, dat, jc, tgt, lat);
    n_total++; if (acc !== 1'b1) $display("FAIL sw_accept timed out"); else n_pass++;
    n_total++; if (wbc != 0 || jc != 0) $display("FAIL sw_no_pulse got wb=%0d jmp=%0d want 0 0", wbc, jc); else n_pass++;
    issue(enc_i(6'h23, 5'd0, 5'd7, 16'h0004), acc, wbc, rg, dat, jc, tgt, lat);
    n_total++; if (wbc != 1 || rg !== 5'd7) $display("FAIL lw_wb got cnt=%0d reg=%0d want 1 7", wbc, rg); else n_pass++;
    n_total++; if (dat !== 32'h0000_3456) $display("FAIL lw_data got %h want 00003456", dat); else n_pass++;
    @(negedge clk);
    switch = 1'b0; dbg_sel = 5'd7;
    @(posedge clk); #1;
    n_total++; if (led !== 8'h56) $display("FAIL led_reg7 got %h want 56", led); else n_pass++;
    // Write to $0 pulses but leaves $0 at zero
    issue(enc_i(6'h08, 5'd0, 5'd0, 16'h0009), acc, wbc, rg, dat, jc, tgt, lat);
    n_total++; if (wbc != 1 || rg !== 5'd0 || dat !== 32'd9) $display("FAIL zero_wb got cnt=%0d reg=%0d data=%h want 1 0 9", wbc, rg, dat); else n_pass++;
    @(negedge clk);
    dbg_sel = 5'd0;
    @(posedge clk); #1;
    n_total++; if (led !== 8'h00) $display("FAIL led_reg0 got %h want 00", led); else n_pass++;
  endtask

  task automatic test_jump_illegal();
    bit acc; int wbc, jc, lat; logic [4:0] rg; logic [31:0] dat, tgt;
    issue(32'h0812_3456, acc, wbc, rg, dat, jc, tgt, lat);
    n_total++; if (jc != 1) $display("FAIL j_pulse_count got %0d want 1", jc); else n_pass++;
    n_total++; if (tgt !== 32'h0048_D158) $display("FAIL j_target got %h want 0048d158", tgt); else n_pass++;
    n_total++; if (wbc != 0) $display("FAIL j_no_wb got %0d want 0", wbc); else n_pass++;
    n_total++; if (lat != 3) $display("FAIL j_latency got %0d want 3", lat); else n_pass++;
    issue(32'hFC00_0000, acc, wbc, rg, dat, jc, tgt, lat);
    n_total++; if (wbc != 0 || jc != 0) $display("FAIL illegal_no_pulse got wb=%0d jmp=%0d want 0 0", wbc, jc); else n_pass++;
    n_total++; if (dut.r_illegal_cnt !== 8'd1) $display("FAIL illegal_cnt got %0d want 1", dut.r_illegal_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[4];
    int a_cyc[8]; int p_cyc[8]; logic [4:0] p_reg[8]; logic [31:0] p_dat[8];
    int na = 0; int np = 0; int rdy_cnt = 0; bit rdy;
    for (int k = 0; k < 4; k++) w[k] = enc_i(6'h08, 5'd0, 5'(9 + k), 16'(16'h0101 + k));
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = w[0];
    for (int c = 0; c < 24; c++) begin
      rdy = instr_ready;
      if (c < 16 && rdy) rdy_cnt++;
      @(posedge clk); #1;
      if (wb_valid && np < 8) begin
        p_cyc[np] = c; p_reg[np] = wb_reg; p_dat[np] = wb_data; np++;
      end
      if (rdy && instr_valid && na < 8) begin
        a_cyc[na] = c; na++;
        if (na < 4) instr_data = w[na];
        else begin instr_valid = 1'b0; instr_data = 32'd0; end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    n_total++; if (na != 4) $display("FAIL b2b_accepts got %0d want 4", na); else n_pass++;
    n_total++; if (rdy_cnt != 4) $display("FAIL b2b_ready_cycles got %0d want 4", rdy_cnt); else n_pass++;
    n_total++; if (np != 4) $display("FAIL b2b_pulses got %0d want 4", np); else n_pass++;
    if (na == 4 && np == 4) begin
      for (int k = 0; k < 4; k++) begin
        n_total++; if (a_cyc[k] != 4 * k) $display("FAIL b2b_accept_cycle[%0d] got %0d want %0d", k, a_cyc[k], 4 * k); else n_pass++;
        n_total++; if (p_cyc[k] != a_cyc[k] + 3) $display("FAIL b2b_pulse_cycle[%0d] got %0d want %0d", k, p_cyc[k], a_cyc[k] + 3); else n_pass++;
        n_total++; if (p_reg[k] !== 5'(9 + k) || p_dat[k] !== 32'(32'h0101 + k))
          $display("FAIL b2b_wb[%0d] got reg=%0d data=%h want %0d %h", k, p_reg[k], p_dat[k], 9 + k, 32'h0101 + k); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    bit acc = 1'b0; int wbc = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = enc_i(6'h08, 5'd0, 5'd8, 16'h0005);
    for (int i = 0; i < 10; i++) begin
      if (instr_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    n_total++; if (acc !== 1'b1) $display("FAIL rst_mid_accept timed out"); else n_pass++;
    @(posedge clk); #1;          // accepted, now in READ
    instr_valid = 1'b0;
    @(posedge clk); #2;          // now in EXEC
    rst_n = 1'b0;
    #1;
    n_total++; if (instr_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", instr_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (wb_valid) wbc++;
    end
    n_total++; if (wbc != 0) $display("FAIL rst_mid_no_wb got %0d want 0", wbc); else n_pass++;
    @(negedge clk);
    switch = 1'b0; dbg_sel = 5'd8;
    @(posedge clk); #1;
    n_total++; if (led !== 8'h00) $display("FAIL rst_mid_reg8 got %h want 00", led); else n_pass++;
    @(negedge clk);
    switch = 1'b1;
    @(posedge clk); #1;
    n_total++; if (led !== 8'h00) $display("FAIL rst_mid_retired got %h want 00", led); else n_pass++;
    n_total++; if (dut.r_illegal_cnt !== 8'd0) $display("FAIL rst_mid_illegal got %0d want 0", dut.r_illegal_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_mem();
    test_jump_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
